// File: rtl/i2c_wb_pkg.sv
// Shared definitions for the OpenCores i2c_master_top register map.
// Used by the arbiter and by every requester FSM that talks to the core.
package i2c_wb_pkg;

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_RXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [2:0] ADR_SR     = 3'd4;

    localparam int CR_STA  = 7;
    localparam int CR_STO  = 6;
    localparam int CR_RD   = 5;
    localparam int CR_WR   = 4;
    localparam int CR_NACK = 3;
    localparam int CR_IACK = 0;

    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;
    localparam int SR_IF    = 0;

    // CR value that issues a bare STOP condition
    localparam logic [7:0] CMD_STOP = 8'h40;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after
// `last`, wrapping around, reported as one-hot and as an index.
module i2c_rr_pick
    import i2c_wb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_idx
);

    logic found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        // Indices above `last` first, then wrap to the low indices
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j > int'(last))) begin
                found    = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j <= int'(last))) begin
                found    = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_wb_arbiter.sv
// Round-robin owner arbiter in front of one i2c_master_top Wishbone port,
// with a watchdog that reclaims a stalled owner and sends STOP to the core.
module i2c_wb_arbiter
    import i2c_wb_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic [NREQ-1:0]   req_cyc,
    input  logic [NREQ-1:0]   req_we,
    input  logic [3*NREQ-1:0] req_adr,
    input  logic [8*NREQ-1:0] req_dat,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ack,
    output logic [7:0]        req_rdat,
    output logic [NREQ-1:0]   gnt,
    output logic              m_cyc,
    output logic              m_we,
    output logic [2:0]        m_adr,
    output logic [7:0]        m_dat,
    input  logic              m_ack,
    input  logic [7:0]        m_rdat,
    output logic              timeout_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] OWN       = 2'd1;
    localparam logic [1:0] ABORT_WR  = 2'd2;
    localparam logic [1:0] ABORT_ACK = 2'd3;

    logic [1:0]      state;
    logic [IW-1:0]   last;
    logic            busy;
    logic [15:0]     wd_cnt;
    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            own_cyc;
    logic            own_we;
    logic            own_lock;
    logic [2:0]      own_adr;
    logic [7:0]      own_dat;
    logic            fwd;
    logic            release_own;
    logic            wd_fire;

    i2c_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req      (req_cyc | req_lock),
        .last     (last),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // gnt is one-hot in OWN and zero elsewhere, so it doubles as the owner select
    always_comb begin
        own_cyc  = 1'b0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        own_adr  = '0;
        own_dat  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                own_cyc  = req_cyc[i];
                own_we   = req_we[i];
                own_lock = req_lock[i];
                own_adr  = req_adr[3*i +: 3];
                own_dat  = req_dat[8*i +: 8];
            end
        end
    end

    assign fwd         = (state == OWN) && own_cyc;
    assign release_own = !own_cyc && !own_lock && !busy;
    assign wd_fire     = (TIMEOUT != 16'd0) && (wd_cnt == TIMEOUT) && !busy;

    always_comb begin
        m_cyc = 1'b0;
        m_we  = 1'b0;
        m_adr = '0;
        m_dat = '0;
        case (state)
            OWN: begin
                m_cyc = own_cyc;
                m_we  = own_cyc & own_we;
                m_adr = own_cyc ? own_adr : 3'd0;
                m_dat = own_cyc ? own_dat : 8'd0;
            end
            ABORT_WR: begin
                m_cyc = 1'b1;
                m_we  = 1'b1;
                m_adr = ADR_CR;
                m_dat = CMD_STOP;
            end
            default: ;
        endcase
    end

    assign req_ack   = (state == OWN) ? (gnt & {NREQ{m_ack}}) : '0;
    assign req_rdat  = m_rdat;
    assign timeout_o = (state == ABORT_ACK) && m_ack;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state  <= IDLE;
            gnt    <= '0;
            last   <= IW'(NREQ - 1);
            busy   <= 1'b0;
            wd_cnt <= '0;
        end else begin
            if (m_ack)
                busy <= 1'b0;
            else if (fwd)
                busy <= 1'b1;

            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (|pick) begin
                        gnt   <= pick;
                        last  <= pick_idx;
                        state <= OWN;
                    end
                end
                OWN: begin
                    // Saturating idle counter; any forwarded cycle restarts it
                    if (fwd)
                        wd_cnt <= '0;
                    else if (wd_cnt != TIMEOUT)
                        wd_cnt <= wd_cnt + 16'd1;

                    if (release_own) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end else if (wd_fire) begin
                        gnt   <= '0;
                        state <= ABORT_WR;
                    end
                end
                ABORT_WR:  state <= ABORT_ACK;
                ABORT_ACK: if (m_ack) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Self-checking bench for i2c_wb_arbiter with a small i2c_master_top bus model.
module tb_i2c_wb_arbiter;
    import i2c_wb_pkg::*;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [1:0]  req_cyc = '0;
    logic [1:0]  req_we = '0;
    logic [5:0]  req_adr = '0;
    logic [15:0] req_dat = '0;
    logic [1:0]  req_lock = '0;
    logic [1:0]  req_ack;
    logic [7:0]  req_rdat;
    logic [1:0]  gnt;
    logic        m_cyc;
    logic        m_we;
    logic [2:0]  m_adr;
    logic [7:0]  m_dat;
    logic        m_ack;
    logic [7:0]  m_rdat;
    logic        timeout_o;

    int total = 0;
    int bad = 0;

    int          ack_dly = 0;
    int          wcnt;
    logic [7:0]  sr_reads;
    logic [11:0] wlog[$];

    typedef struct {
        int         id;
        bit         chk;
        logic [7:0] dat;
    } exp_t;
    exp_t sb[$];
    bit   mon_stop;

    i2c_wb_arbiter #(.NREQ(2), .TIMEOUT(16'd20)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .req_cyc   (req_cyc),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .req_lock  (req_lock),
        .req_ack   (req_ack),
        .req_rdat  (req_rdat),
        .gnt       (gnt),
        .m_cyc     (m_cyc),
        .m_we      (m_we),
        .m_adr     (m_adr),
        .m_dat     (m_dat),
        .m_ack     (m_ack),
        .m_rdat    (m_rdat),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    // Core model: registered ack after ack_dly extra cycles; SR reads count up from 8'h30
    assign m_rdat = (m_adr == ADR_SR && !m_we) ? (8'h30 + sr_reads) : 8'hEE;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_ack    <= 1'b0;
            wcnt     <= 0;
            sr_reads <= '0;
            wlog.delete();
        end else if (m_ack) begin
            m_ack <= 1'b0;
            wcnt  <= 0;
            if (m_cyc && !m_we && m_adr == ADR_SR) sr_reads <= sr_reads + 8'd1;
        end else if (m_cyc) begin
            if (wcnt >= ack_dly) begin
                m_ack <= 1'b1;
                wlog.push_back({m_we, m_adr, m_dat});
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, required to have finished");
        $fatal(1, "global timeout");
    end

    task automatic do_reset();
        arstn    = 1'b0;
        req_cyc  = '0;
        req_we   = '0;
        req_lock = '0;
        req_adr  = '0;
        req_dat  = '0;
        ack_dly  = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input int i, input logic we, input logic [2:0] adr, input logic [7:0] dat);
        int n;
        @(posedge clk);
        #1;
        req_we[i]         = we;
        req_adr[3*i +: 3] = adr;
        req_dat[8*i +: 8] = dat;
        req_cyc[i]        = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ack[i] && n < 200);
        total++;
        if (!req_ack[i]) begin
            bad++;
            $display("FAIL xfer_ack_req%0d: no ack within %0d cycles, required an ack", i, n);
        end
        @(posedge clk);
        #1 req_cyc[i] = 1'b0;
    endtask

    task automatic sb_monitor();
        exp_t       e;
        logic [1:0] oh;
        while (!mon_stop) begin
            @(negedge clk);
            if (req_ack != 2'b00) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra_ack: req_ack=%b, required no ack", req_ack);
                end else begin
                    e  = sb.pop_front();
                    oh = 2'(1 << e.id);
                    if (req_ack !== oh || gnt !== oh || (e.chk && req_rdat !== e.dat)) begin
                        bad++;
                        $display("FAIL sb_ack: req_ack=%b gnt=%b rdat=%h, required ack=gnt=%b rdat=%h",
                                 req_ack, gnt, req_rdat, oh, e.dat);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        arstn    = 1'b0;
        ack_dly  = 100;
        req_we   = '0;
        req_adr  = {3'd3, ADR_SR};
        req_cyc  = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({gnt, req_ack, m_cyc, timeout_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b ack=%b m_cyc=%b to=%b, required all 0", gnt, req_ack, m_cyc, timeout_o);
        end
        total++;
        if (req_rdat !== m_rdat) begin
            bad++;
            $display("FAIL reset_rdat: req_rdat=%h, required m_rdat=%h", req_rdat, m_rdat);
        end
        @(posedge clk);
        #1 arstn = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 2'b00) begin
            bad++;
            $display("FAIL reset_gnt_early: gnt=%b, required 00", gnt);
        end
        @(negedge clk);
        total++;
        if (gnt !== 2'b01 || m_cyc !== 1'b1 || m_adr !== ADR_SR) begin
            bad++;
            $display("FAIL reset_first_gnt: gnt=%b m_cyc=%b m_adr=%0d, required 01 1 4", gnt, m_cyc, m_adr);
        end
        @(posedge clk);
        #1 req_cyc[0] = 1'b0;
        @(negedge clk);
        total++;
        if (m_cyc !== 1'b0 || gnt !== 2'b01) begin
            bad++;
            $display("FAIL reset_follow_owner: m_cyc=%b gnt=%b, required 0 01", m_cyc, gnt);
        end
    endtask

    task automatic test_lock();
        do_reset();
        repeat (4) sb.push_back('{0, 1'b0, 8'h00});
        sb.push_back('{1, 1'b1, 8'h30});
        mon_stop = 1'b0;
        fork
            sb_monitor();
            begin
                fork
                    begin
                        @(posedge clk);
                        #1 req_lock[0] = 1'b1;
                        wb_xfer(0, 1'b1, ADR_TXR, 8'hA0);
                        wb_xfer(0, 1'b1, ADR_CR,  8'h90);
                        wb_xfer(0, 1'b1, ADR_TXR, 8'h55);
                        wb_xfer(0, 1'b1, ADR_CR,  8'h10);
                        req_lock[0] = 1'b0;
                        @(negedge clk);
                        @(negedge clk);
                        total++;
                        if (gnt !== 2'b00) begin
                            bad++;
                            $display("FAIL lock_release_idle: gnt=%b, required 00", gnt);
                        end
                        @(negedge clk);
                        total++;
                        if (gnt !== 2'b10) begin
                            bad++;
                            $display("FAIL lock_regrant: gnt=%b, required 10", gnt);
                        end
                    end
                    begin
                        repeat (3) @(posedge clk);
                        wb_xfer(1, 1'b0, ADR_SR, 8'h00);
                    end
                join
                repeat (2) @(negedge clk);
                mon_stop = 1'b1;
            end
        join
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL lock_sb_left: %0d entries left, required 0", sb.size());
        end
        total++;
        if (wlog.size() != 5 || wlog[1] !== {1'b1, ADR_CR, 8'h90}) begin
            bad++;
            $display("FAIL lock_core_log: size=%0d, required 5 with CR write 90 second", wlog.size());
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int k = 0; k < 6; k++) sb.push_back('{k % 2, 1'b1, 8'h30 + 8'(k)});
        mon_stop = 1'b0;
        fork
            sb_monitor();
            begin
                fork
                    for (int a = 0; a < 3; a++) wb_xfer(0, 1'b0, ADR_SR, 8'h00);
                    for (int b = 0; b < 3; b++) wb_xfer(1, 1'b0, ADR_SR, 8'h00);
                join
                repeat (2) @(negedge clk);
                mon_stop = 1'b1;
            end
        join
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL alt_sb_left: %0d entries left, required 0", sb.size());
        end
    endtask

    task automatic test_lock_pending();
        exp_t e;
        int   n;
        bit   got;
        do_reset();
        ack_dly = 3;
        @(posedge clk);
        #1;
        req_lock[0]   = 1'b1;
        req_we[0]     = 1'b0;
        req_adr[2:0]  = ADR_SR;
        req_cyc[0]    = 1'b1;
        sb.push_back('{0, 1'b1, 8'h30});
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            req_lock[0] = 1'b0;
            total++;
            if (gnt !== 2'b01) begin
                bad++;
                $display("FAIL pend_hold: cycle %0d gnt=%b, required 01", n, gnt);
            end
            if (req_ack[0]) begin
                got = 1'b1;
                e   = sb.pop_front();
                total++;
                if (req_rdat !== e.dat) begin
                    bad++;
                    $display("FAIL pend_rdat: rdat=%h, required %h", req_rdat, e.dat);
                end
            end
        end
        total++;
        if (!got || n != 5) begin
            bad++;
            $display("FAIL pend_ack_time: got=%0d after %0d cycles, required ack after 5", got, n);
        end
        @(posedge clk);
        #1 req_cyc[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (gnt !== 2'b00) begin
            bad++;
            $display("FAIL pend_release: gnt=%b, required 00", gnt);
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        int   n;
        do_reset();
        @(posedge clk);
        #1;
        req_lock[0]  = 1'b1;
        req_we[1]    = 1'b0;
        req_adr[5:3] = ADR_SR;
        req_cyc[1]   = 1'b1;
        sb.push_back('{1, 1'b1, 8'h30});
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (gnt !== 2'b01) break;
            n++;
        end
        total++;
        if (n != 21) begin
            bad++;
            $display("FAIL wd_hold_cycles: held %0d, required 21", n);
        end
        total++;
        if ({gnt, m_cyc, m_we, m_adr, m_dat} !== {2'b00, 1'b1, 1'b1, ADR_CR, 8'h40}) begin
            bad++;
            $display("FAIL wd_stop_write: gnt=%b cyc=%b we=%b adr=%0d dat=%h, required 00 1 1 4 40",
                     gnt, m_cyc, m_we, m_adr, m_dat);
        end
        @(negedge clk);
        total++;
        if (timeout_o !== 1'b1 || gnt !== 2'b00 || req_ack !== 2'b00) begin
            bad++;
            $display("FAIL wd_pulse: to=%b gnt=%b ack=%b, required 1 00 00", timeout_o, gnt, req_ack);
        end
        total++;
        if (wlog.size() != 1 || wlog[0] !== {1'b1, ADR_CR, 8'h40}) begin
            bad++;
            $display("FAIL wd_core_log: size=%0d, required one CR write of 40", wlog.size());
        end
        @(negedge clk);
        total++;
        if (timeout_o !== 1'b0 || gnt !== 2'b00) begin
            bad++;
            $display("FAIL wd_pulse_end: to=%b gnt=%b, required 0 00", timeout_o, gnt);
        end
        @(negedge clk);
        total++;
        if (gnt !== 2'b10) begin
            bad++;
            $display("FAIL wd_next_owner: gnt=%b, required 10", gnt);
        end
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (req_ack !== 2'b10 || req_rdat !== e.dat) begin
            bad++;
            $display("FAIL wd_next_read: ack=%b rdat=%h, required 10 %h", req_ack, req_rdat, e.dat);
        end
        @(posedge clk);
        #1;
        req_cyc[1]  = 1'b0;
        req_lock[0] = 1'b0;
    endtask

    task automatic test_reset_abort();
        int n;
        do_reset();
        @(posedge clk);
        #1 req_lock[0] = 1'b1;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (m_cyc) break;
            n++;
        end
        total++;
        if (m_cyc !== 1'b1) begin
            bad++;
            $display("FAIL rab_reach_abort: m_cyc=%b after %0d cycles, required 1", m_cyc, n);
        end
        arstn = 1'b0;
        #1;
        total++;
        if ({gnt, req_ack, m_cyc, m_we, m_adr, m_dat, timeout_o} !== 17'b0) begin
            bad++;
            $display("FAIL rab_outputs: gnt=%b ack=%b cyc=%b we=%b adr=%0d dat=%h to=%b, required all 0",
                     gnt, req_ack, m_cyc, m_we, m_adr, m_dat, timeout_o);
        end
        req_lock[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_cyc || gnt != 2'b00) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL rab_quiet: %0d active cycles after reset, required 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_alternate();
        test_lock_pending();
        test_watchdog();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
